// File: rtl/nx_control_driver.sv
// Host-side burst initiator for the nx_control message protocol: programs trigger mask and
// interval, starts the mesh, polls STATUS until it goes idle, then reads back CYCLES.
package nx_control_pkg;
  localparam int MESSAGE_WIDTH = 32;

  typedef enum logic [2:0] {
    CMD_ACTIVE   = 3'd0,
    CMD_STATUS   = 3'd1,
    CMD_CYCLES   = 3'd2,
    CMD_INTERVAL = 3'd3,
    CMD_TRIGMASK = 3'd4
  } control_command_t;

  localparam int RX_PYLD_WIDTH = MESSAGE_WIDTH - $bits(control_command_t);

  typedef struct packed {
    control_command_t           command;
    logic [RX_PYLD_WIDTH-1:0]   payload;
  } control_message_t;

  // Raw response word; for STATUS, bit 0 is the mesh active flag.
  typedef logic [MESSAGE_WIDTH-1:0] control_response_t;
endpackage

module nx_control_driver
  import nx_control_pkg::*;
#(
  parameter int COLUMNS   = 3,
  parameter int POLL_GAP  = 16,
  parameter int MAX_POLLS = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [RX_PYLD_WIDTH-1:0] i_interval,
  input  logic [COLUMNS-1:0]       i_trig_mask,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [MESSAGE_WIDTH-1:0] o_cycles,
  output control_message_t         o_cmd_data,
  output logic                     o_cmd_valid,
  input  logic                     i_cmd_ready,
  input  control_response_t        i_resp_data,
  input  logic                     i_resp_valid,
  output logic                     o_resp_ready,
  output logic [3:0]               o_dbg_state
);

  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(MAX_POLLS + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SEND_MASK, S_SEND_INTERVAL, S_SEND_ACTIVE, S_POLL_WAIT,
    S_SEND_STATUS, S_WAIT_STATUS, S_SEND_CYCLES, S_WAIT_CYCLES, S_SEND_STOP
  } state_t;

  state_t                   state;
  logic [RX_PYLD_WIDTH-1:0] interval_q;
  logic [COLUMNS-1:0]       mask_q;
  logic [GW-1:0]            gap_cnt;
  logic [PW-1:0]            poll_cnt;
  logic                     abort_pend;

  // Handshake: a command moves on a cycle where o_cmd_valid && i_cmd_ready; once raised, valid
  // and data hold until that cycle. Responses are taken whenever i_resp_valid && o_resp_ready.
  logic xfer, resp_take, abort_req, in_wait;
  assign xfer      = o_cmd_valid && i_cmd_ready;
  assign resp_take = i_resp_valid && o_resp_ready;
  assign abort_req = abort_pend || i_abort;
  assign in_wait   = (state == S_WAIT_STATUS) || (state == S_WAIT_CYCLES);
  assign o_dbg_state = state;

  function automatic control_message_t msg(control_command_t c, logic [RX_PYLD_WIDTH-1:0] p);
    control_message_t m;
    m.command = c;
    m.payload = p;
    return m;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      interval_q   <= '0;
      mask_q       <= '0;
      gap_cnt      <= '0;
      poll_cnt     <= '0;
      abort_pend   <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_cycles     <= '0;
      o_cmd_data   <= '0;
      o_cmd_valid  <= 1'b0;
      o_resp_ready <= 1'b0;
    end else begin
      o_resp_ready <= 1'b1;
      o_done       <= 1'b0;
      // Anything arriving outside a WAIT state is a stray response: swallow it and flag it.
      o_error      <= resp_take && !in_wait;
      if (i_abort && state != S_IDLE && state != S_SEND_STOP) abort_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (i_start) begin
            if (i_interval == '0) begin
              o_error <= 1'b1;
            end else begin
              interval_q  <= i_interval;
              mask_q      <= i_trig_mask;
              poll_cnt    <= '0;
              abort_pend  <= 1'b0;
              o_busy      <= 1'b1;
              o_cmd_valid <= 1'b1;
              o_cmd_data  <= msg(CMD_TRIGMASK, RX_PYLD_WIDTH'(i_trig_mask));
              state       <= S_SEND_MASK;
            end
          end
        end
        S_SEND_MASK, S_SEND_INTERVAL: begin
          if (xfer) begin
            if (abort_req) begin
              o_cmd_data <= msg(CMD_ACTIVE, '0);
              abort_pend <= 1'b0;
              state      <= S_SEND_STOP;
            end else if (state == S_SEND_MASK) begin
              o_cmd_data <= msg(CMD_INTERVAL, interval_q);
              state      <= S_SEND_INTERVAL;
            end else begin
              o_cmd_data <= msg(CMD_ACTIVE, RX_PYLD_WIDTH'(1));
              state      <= S_SEND_ACTIVE;
            end
          end
        end
        S_SEND_ACTIVE: begin
          if (xfer) begin
            if (abort_req) begin
              o_cmd_data <= msg(CMD_ACTIVE, '0);
              abort_pend <= 1'b0;
              state      <= S_SEND_STOP;
            end else begin
              o_cmd_valid <= 1'b0;
              gap_cnt     <= '0;
              state       <= S_POLL_WAIT;
            end
          end
        end
        S_POLL_WAIT: begin
          if (abort_req) begin
            o_cmd_valid <= 1'b1;
            o_cmd_data  <= msg(CMD_ACTIVE, '0);
            abort_pend  <= 1'b0;
            state       <= S_SEND_STOP;
          end else if (gap_cnt == GW'(POLL_GAP - 1)) begin
            o_cmd_valid <= 1'b1;
            o_cmd_data  <= msg(CMD_STATUS, '0);
            state       <= S_SEND_STATUS;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        S_SEND_STATUS: begin
          if (xfer) begin
            o_cmd_valid <= 1'b0;
            state       <= S_WAIT_STATUS;
          end
        end
        S_WAIT_STATUS: begin
          if (resp_take) begin
            if (abort_req || (i_resp_data[0] && poll_cnt == PW'(MAX_POLLS - 1))) begin
              // Abort takes priority and is silent; a timeout reports an error.
              o_error     <= !abort_req;
              o_cmd_valid <= 1'b1;
              o_cmd_data  <= msg(CMD_ACTIVE, '0);
              abort_pend  <= 1'b0;
              state       <= S_SEND_STOP;
            end else if (!i_resp_data[0]) begin
              o_cmd_valid <= 1'b1;
              o_cmd_data  <= msg(CMD_CYCLES, '0);
              state       <= S_SEND_CYCLES;
            end else begin
              poll_cnt <= poll_cnt + PW'(1);
              gap_cnt  <= '0;
              state    <= S_POLL_WAIT;
            end
          end
        end
        S_SEND_CYCLES: begin
          if (xfer) begin
            o_cmd_valid <= 1'b0;
            state       <= S_WAIT_CYCLES;
          end
        end
        S_WAIT_CYCLES: begin
          // Only an abort latched before the response cancels the read-back.
          if (resp_take) begin
            if (abort_pend) begin
              o_cmd_valid <= 1'b1;
              o_cmd_data  <= msg(CMD_ACTIVE, '0);
              abort_pend  <= 1'b0;
              state       <= S_SEND_STOP;
            end else begin
              o_cycles   <= i_resp_data;
              o_done     <= 1'b1;
              o_busy     <= 1'b0;
              abort_pend <= 1'b0;
              state      <= S_IDLE;
            end
          end
        end
        S_SEND_STOP: begin
          if (xfer) begin
            o_cmd_valid <= 1'b0;
            o_busy      <= 1'b0;
            abort_pend  <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          o_cmd_valid <= 1'b0;
          o_busy      <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nx_control_driver.sv
// Directed bench for nx_control_driver: table of full bursts against a small responder model,
// plus hand-written sequences for zero interval, aborts, mid-burst reset and stray responses.
module tb_nx_control_driver;
  import nx_control_pkg::*;

  localparam int COLUMNS      = 3;
  localparam int POLL_GAP     = 4;
  localparam int MAX_POLLS    = 4;
  localparam int RESP_LAT     = 2;
  localparam int STALL_CYCLES = 5;
  localparam int RW           = RX_PYLD_WIDTH;

  logic                     clk, rst, start, abort_req;
  logic [RW-1:0]            interval;
  logic [COLUMNS-1:0]       trig_mask;
  logic                     busy, done, error, cmd_valid, cmd_ready, resp_valid, resp_ready;
  logic [MESSAGE_WIDTH-1:0] cycles;
  control_message_t         cmd_data;
  control_response_t        resp_data;
  logic [3:0]               dbg_state;

  nx_control_driver #(.COLUMNS(COLUMNS), .POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort_req),
    .i_interval(interval), .i_trig_mask(trig_mask),
    .o_busy(busy), .o_done(done), .o_error(error), .o_cycles(cycles),
    .o_cmd_data(cmd_data), .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
    .i_resp_data(resp_data), .i_resp_valid(resp_valid), .o_resp_ready(resp_ready),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [MESSAGE_WIDTH-1:0] mk(control_command_t c, logic [RW-1:0] p);
    return {c, p};
  endfunction

  // ---------------- scoreboard + responder model ----------------
  logic [MESSAGE_WIDTH-1:0] exp_q[$];
  logic [MESSAGE_WIDTH-1:0] got_q[$];
  logic [MESSAGE_WIDTH-1:0] resp_q[$];
  int            done_cnt, err_cnt, status_seen, busy_polls, resp_delay;
  logic [RW-1:0] model_interval;

  always @(posedge clk) begin
    if (rst) begin
      resp_q.delete();
      resp_delay = 0;
    end else begin
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (cmd_valid && cmd_ready) begin
        got_q.push_back(cmd_data);
        case (cmd_data.command)
          CMD_INTERVAL: model_interval = cmd_data.payload;
          CMD_STATUS: begin
            resp_q.push_back((status_seen < busy_polls) ? 32'd1 : 32'd0);
            status_seen++;
          end
          CMD_CYCLES: resp_q.push_back(MESSAGE_WIDTH'(model_interval));
          default: ;
        endcase
      end
    end
  end

  // Responses and ready are driven on the falling edge; stalls hold ready low per command.
  logic             stall_en = 1'b0;
  int               stall_cnt = 0, stall_seen = 0, stall_errs = 0;
  logic             prev_stalled = 1'b0;
  control_message_t prev_data;

  always @(negedge clk) begin
    if (prev_stalled) begin
      stall_seen++;
      if (!cmd_valid || cmd_data !== prev_data) stall_errs++;
    end
    resp_valid = 1'b0;
    if (resp_q.size() > 0) begin
      if (resp_delay == RESP_LAT) begin
        resp_valid = 1'b1;
        resp_data  = resp_q.pop_front();
        resp_delay = 0;
      end else begin
        resp_delay++;
      end
    end
    if (cmd_ready) stall_cnt = 0;
    if (!stall_en) cmd_ready = 1'b1;
    else if (cmd_valid && stall_cnt < STALL_CYCLES) begin
      cmd_ready = 1'b0;
      stall_cnt++;
    end else cmd_ready = cmd_valid;
    prev_stalled = cmd_valid && !cmd_ready;
    prev_data    = cmd_data;
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic [RW-1:0]            interval;
    logic [COLUMNS-1:0]       mask;
    int                       busy_polls;
    bit                       stall;
    int                       exp_done;
    int                       exp_err;
    int                       exp_status;
    logic [MESSAGE_WIDTH-1:0] exp_cycles;
  } vec_t;

  vec_t vecs[6];

  task automatic clear_sb(input int polls, input bit stall);
    got_q.delete();
    exp_q.delete();
    done_cnt    = 0;
    err_cnt     = 0;
    status_seen = 0;
    busy_polls  = polls;
    stall_en    = stall;
  endtask

  task automatic start_burst(input logic [RW-1:0] iv, input logic [COLUMNS-1:0] m);
    @(negedge clk);
    start = 1'b1; interval = iv; trig_mask = m;
    @(negedge clk);
    start = 1'b0; interval = ~iv; trig_mask = ~m;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, busy, 0);
    repeat (RESP_LAT + 4) @(negedge clk);
  endtask

  task automatic wait_cmds(input int cnt);
    int n = 0;
    while (got_q.size() < cnt && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_cmds_timeout", got_q.size(), cnt);
  endtask

  task automatic compare_cmds(input string name);
    check({name, "_cmd_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_cmd%0d", name, i), got_q[i], exp_q[i]);
  endtask

  logic [MESSAGE_WIDTH-1:0] last_cycles;

  task automatic run_vec(input string name, input vec_t v);
    clear_sb(v.busy_polls, v.stall);
    start_burst(v.interval, v.mask);
    check({name, "_valid_latency"}, cmd_valid, 1);
    check({name, "_busy_on_start"}, busy, 1);
    wait_idle(name);
    exp_q.push_back(mk(CMD_TRIGMASK, RW'(v.mask)));
    exp_q.push_back(mk(CMD_INTERVAL, v.interval));
    exp_q.push_back(mk(CMD_ACTIVE, RW'(1)));
    for (int i = 0; i < v.exp_status; i++) exp_q.push_back(mk(CMD_STATUS, '0));
    exp_q.push_back(v.exp_done != 0 ? mk(CMD_CYCLES, '0) : mk(CMD_ACTIVE, '0));
    compare_cmds(name);
    check({name, "_done_pulses"}, done_cnt, v.exp_done);
    check({name, "_error_pulses"}, err_cnt, v.exp_err);
    check({name, "_cycles"}, cycles, v.exp_cycles);
    check({name, "_resp_drained"}, resp_q.size(), 0);
    check({name, "_valid_idle"}, cmd_valid, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; abort_req = 1'b0; interval = '0; trig_mask = '0;
    cmd_ready = 1'b1; resp_valid = 1'b0; resp_data = '0;
    clear_sb(0, 1'b0);

    vecs[0] = '{29'd10, 3'b111, 2, 1'b0, 1, 0, 3, 32'd10};
    vecs[1] = '{29'd10, 3'b111, 2, 1'b1, 1, 0, 3, 32'd10};
    vecs[2] = '{29'd5, 3'b010, 0, 1'b0, 1, 0, 1, 32'd5};
    vecs[3] = '{29'h1FFFFFFF, 3'b101, 3, 1'b0, 1, 0, 4, 32'h1FFFFFFF};
    vecs[4] = '{29'd7, 3'b001, 99, 1'b0, 0, 1, 4, 32'h1FFFFFFF};
    vecs[5] = '{29'd1, 3'b000, 99, 1'b1, 0, 1, 4, 32'h1FFFFFFF};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cycles", cycles, 0);
    check("rst_resp_ready", resp_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("resp_ready_after_rst", resp_ready, 1);
    last_cycles = '0;

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Zero interval: rejected with one error pulse, no command, never busy.
    clear_sb(0, 1'b0);
    start_burst('0, 3'b111);
    check("zero_error", error, 1);
    check("zero_busy", busy, 0);
    check("zero_valid", cmd_valid, 0);
    @(negedge clk);
    check("zero_error_pulse", error, 0);
    check("zero_no_cmd", got_q.size(), 0);

    // Abort while idling between polls: straight to ACTIVE(0).
    clear_sb(99, 1'b0);
    start_burst(29'd20, 3'b011);
    wait_cmds(3);
    abort_req = 1'b1;
    @(negedge clk);
    abort_req = 1'b0;
    wait_idle("abort_poll");
    exp_q = '{mk(CMD_TRIGMASK, RW'(3)), mk(CMD_INTERVAL, 29'd20), mk(CMD_ACTIVE, RW'(1)),
              mk(CMD_ACTIVE, '0)};
    compare_cmds("abort_poll");
    check("abort_poll_done", done_cnt, 0);
    check("abort_poll_error", err_cnt, 0);

    // Abort with a STATUS outstanding: the response is eaten silently, then ACTIVE(0).
    clear_sb(99, 1'b0);
    start_burst(29'd20, 3'b110);
    wait_cmds(4);
    abort_req = 1'b1;
    @(negedge clk);
    abort_req = 1'b0;
    wait_idle("abort_wait");
    exp_q = '{mk(CMD_TRIGMASK, RW'(6)), mk(CMD_INTERVAL, 29'd20), mk(CMD_ACTIVE, RW'(1)),
              mk(CMD_STATUS, '0), mk(CMD_ACTIVE, '0)};
    compare_cmds("abort_wait");
    check("abort_wait_done", done_cnt, 0);
    check("abort_wait_error", err_cnt, 0);
    check("abort_wait_resp_eaten", resp_q.size(), 0);
    check("abort_wait_cycles_held", cycles, 32'h1FFFFFFF);

    // Reset while waiting on STATUS abandons the burst; a fresh burst then runs cleanly.
    clear_sb(99, 1'b0);
    start_burst(29'd20, 3'b111);
    wait_cmds(4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", cmd_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cycles", cycles, 0);
    repeat (RESP_LAT + 3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec("after_rst", vecs[0]);

    // Stray response in IDLE: error pulse, nothing else changes.
    clear_sb(0, 1'b0);
    resp_q.push_back(32'h1234);
    repeat (RESP_LAT + 4) @(negedge clk);
    check("stray_error", err_cnt, 1);
    check("stray_done", done_cnt, 0);
    check("stray_busy", busy, 0);
    check("stray_cycles_held", cycles, 32'd10);

    check("stall_data_stable", stall_errs, 0);
    check("stall_observed", stall_seen > 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
